// File: rtl/elevator_call_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared constants, the dispatch state type and the round-robin car picker
// used by the elevator call dispatcher and its pending-call FIFO.
// No ports (package).
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int NUM_CARS  = 4;
    localparam int FLOOR_W   = 8;
    localparam int CAR_IDX_W = 2;

    typedef enum logic {
        IDLE,
        ISSUE
    } dispatch_state_e;

    // Returns the first set bit of i_free, searching from i_last+1 upward
    // modulo NUM_CARS. The caller qualifies the result with |i_free.
    function automatic logic [CAR_IDX_W-1:0] rr_pick(
        input logic [CAR_IDX_W-1:0] i_last,
        input logic [NUM_CARS-1:0]  i_free
    );
        logic [CAR_IDX_W-1:0] w_idx;
        logic [CAR_IDX_W-1:0] w_cand;
        logic                 w_found;
        w_idx   = i_last;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_CARS; k++) begin
            // Index arithmetic wraps naturally because NUM_CARS is 2**CAR_IDX_W.
            w_cand = i_last + CAR_IDX_W'(k);
            if (!w_found && i_free[w_cand]) begin
                w_idx   = w_cand;
                w_found = 1'b1;
            end
        end
        return w_idx;
    endfunction

endpackage

// File: rtl/elevator_call_dispatcher_if.sv
// -----------------------------------------------------------------------------
// elevator_call_dispatcher_if
// Bundles the hall-call input handshake, the car controller handshake and the
// dispatcher status outputs.
//   master : dispatcher side (drives call_ready, route_*, car_valid, status)
//   slave  : environment side (drives call_valid/call_floor, car_busy/car_ack)
// Signals:
//   call_valid, call_floor[7:0], call_ready   hall-call push handshake
//   car_busy[3:0], car_ack[3:0]               car controller status / accept
//   route_data[7:0], route_sel[1:0]           demux in / select
//   car_valid[3:0]                            one-hot issue strobe
//   dup_drop, timeout_pulse                   1-cycle event pulses
//   pending[$clog2(DEPTH):0]                  FIFO occupancy
// -----------------------------------------------------------------------------
interface elevator_call_dispatcher_if
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                     call_valid;
    logic [FLOOR_W-1:0]       call_floor;
    logic                     call_ready;
    logic [NUM_CARS-1:0]      car_busy;
    logic [NUM_CARS-1:0]      car_ack;
    logic [FLOOR_W-1:0]       route_data;
    logic [CAR_IDX_W-1:0]     route_sel;
    logic [NUM_CARS-1:0]      car_valid;
    logic                     dup_drop;
    logic                     timeout_pulse;
    logic [$clog2(DEPTH):0]   pending;

    modport master (
        input  call_valid, call_floor, car_busy, car_ack,
        output call_ready, route_data, route_sel, car_valid,
               dup_drop, timeout_pulse, pending
    );

    modport slave (
        output call_valid, call_floor, car_busy, car_ack,
        input  call_ready, route_data, route_sel, car_valid,
               dup_drop, timeout_pulse, pending
    );

endinterface

// File: rtl/elevator_call_dispatcher_fifo.sv
// -----------------------------------------------------------------------------
// call_fifo
// DEPTH x FLOOR_W pending-call queue with a per-entry valid vector so the
// dispatcher can compare an incoming floor against every queued call.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_push, i_data      write i_data at the tail (caller guarantees !o_full)
//   i_pop               drop the head (caller guarantees !o_empty)
//   o_head              floor code at the head
//   o_full, o_empty     occupancy flags
//   o_count             number of stored entries (0..DEPTH)
//   o_entries           raw storage, for the duplicate compare
//   o_entry_valid       bit j set when o_entries[j] holds a queued call
// -----------------------------------------------------------------------------
module call_fifo
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [FLOOR_W-1:0]       i_data,
    output logic [FLOOR_W-1:0]       o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [FLOOR_W-1:0]       o_entries [DEPTH],
    output logic [DEPTH-1:0]         o_entry_valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLOOR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   r_valid;

    // NOTE: the storage array has no reset; r_valid and r_count say which
    // entries mean anything, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // Pointers wrap modulo DEPTH since DEPTH is a power of two.
            if (i_push) begin
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head        = r_mem[r_rd_ptr];
    assign o_full        = (r_count == CNT_W'(DEPTH));
    assign o_empty       = (r_count == '0);
    assign o_count       = r_count;
    assign o_entries     = r_mem;
    assign o_entry_valid = r_valid;

endmodule

// File: rtl/elevator_call_dispatcher.sv
// -----------------------------------------------------------------------------
// elevator_call_dispatcher
// Buffers hall-call floor codes, drops duplicates of calls already queued or
// in flight, and issues each call to a free car chosen round-robin. The
// issue (route_data/route_sel/one-hot car_valid) is held until the chosen
// car acknowledges; the head entry is popped only on that ack.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      elevator_call_dispatcher_if.master (see interface header)
// Parameters:
//   DEPTH    pending-call FIFO entries (power of 2, >= 2)
//   TIMEOUT  ack wait limit in ISSUE cycles (only with DISPATCH_TIMEOUT_EN)
// Build option:
//   DISPATCH_TIMEOUT_EN  when defined, an unacknowledged issue is abandoned
//                        after TIMEOUT cycles and timeout_pulse fires; when
//                        undefined, ISSUE waits indefinitely and
//                        timeout_pulse is tied low.
// -----------------------------------------------------------------------------
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int DEPTH   = 4
`ifdef DISPATCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    elevator_call_dispatcher_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    dispatch_state_e       r_state;
    dispatch_state_e       w_state_nxt;

    logic [FLOOR_W-1:0]    r_route_data;
    logic [CAR_IDX_W-1:0]  r_route_sel;
    logic [NUM_CARS-1:0]   r_car_valid;
    logic [CAR_IDX_W-1:0]  r_last_grant;
    logic                  r_dup_drop;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_dup;
    logic                  w_dup_fifo;
    logic                  w_ack;
    logic [NUM_CARS-1:0]   w_free;
    logic [CAR_IDX_W-1:0]  w_grant_idx;

    logic [FLOOR_W-1:0]    w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [FLOOR_W-1:0]    w_entries [DEPTH];
    logic [DEPTH-1:0]      w_entry_valid;

    call_fifo #(
        .DEPTH (DEPTH)
    ) u_call_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_data        (bus.call_floor),
        .o_head        (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_count       (w_count),
        .o_entries     (w_entries),
        .o_entry_valid (w_entry_valid)
    );

    // ---------------------------------------------------------------------
    // Intake: a duplicate is still handshaken (call_ready depends on full
    // only) but is not written, and is flagged one cycle later.
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_dup_fifo = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_entry_valid[j] && (w_entries[j] == bus.call_floor)) begin
                w_dup_fifo = 1'b1;
            end
        end
    end

    assign w_accept = bus.call_valid && !w_full;
    assign w_dup    = w_dup_fifo ||
                      ((r_state == ISSUE) && (r_route_data == bus.call_floor));
    assign w_push   = w_accept && !w_dup;

    // ---------------------------------------------------------------------
    // Car selection and ack decode
    // ---------------------------------------------------------------------
    assign w_free      = ~bus.car_busy;
    assign w_grant_idx = rr_pick(r_last_grant, w_free);
    assign w_ack       = bus.car_ack[r_route_sel];

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_pulse;
    logic            w_expire;
    logic            w_to_hit;

    // r_to_cnt counts completed un-acked ISSUE cycles, so the cycle in which
    // it equals TIMEOUT-1 is the TIMEOUT-th one; expiry happens at its edge.
    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt        <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            if (w_grant) begin
                r_to_cnt <= '0;
            end else if ((r_state == ISSUE) && !w_ack) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            r_timeout_pulse <= w_expire;
        end
    end

    assign bus.timeout_pulse = r_timeout_pulse;
`else
    assign bus.timeout_pulse = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Dispatch FSM: state register + next-state logic
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pop       = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        w_expire    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty && (|w_free)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // car_busy is deliberately not looked at here; an ack in the
                // expiry cycle takes priority over the timeout.
                if (w_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_expire    = 1'b1;
                    w_state_nxt = IDLE;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Issue registers. route_data/route_sel keep their value after release;
    // only car_valid marks a live issue.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_route_data <= '0;
            r_route_sel  <= '0;
            r_car_valid  <= '0;
            r_last_grant <= CAR_IDX_W'(NUM_CARS - 1);
            r_dup_drop   <= 1'b0;
        end else begin
            r_dup_drop <= w_accept && w_dup;
            if (w_grant) begin
                r_route_sel  <= w_grant_idx;
                r_route_data <= w_head;
                r_car_valid  <= NUM_CARS'(1) << w_grant_idx;
            end
            if (w_pop) begin
                r_car_valid  <= '0;
                r_last_grant <= r_route_sel;
            end
`ifdef DISPATCH_TIMEOUT_EN
            // Abandoned issue: the head stays queued, but the round-robin
            // pointer advances so the retry prefers the next car.
            if (w_expire) begin
                r_car_valid  <= '0;
                r_last_grant <= r_route_sel;
            end
`endif
        end
    end

    assign bus.call_ready = !w_full;
    assign bus.route_data = r_route_data;
    assign bus.route_sel  = r_route_sel;
    assign bus.car_valid  = r_car_valid;
    assign bus.dup_drop   = r_dup_drop;
    assign bus.pending    = w_count;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_elevator_call_dispatcher
// Directed self-checking bench for elevator_call_dispatcher. Inputs are
// driven 1 time unit after a rising edge and outputs sampled at that point.
// The timeout scenario is compiled only with DISPATCH_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elevator_call_dispatcher;
    import elevator_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    elevator_call_dispatcher_if #(.DEPTH(4)) bus();

    elevator_call_dispatcher #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.call_valid = 1'b0;
        bus.call_floor = '0;
        bus.car_busy   = '0;
        bus.car_ack    = '0;
        rst_n          = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] floor);
        bus.call_valid = 1'b1;
        bus.call_floor = floor;
        tick();
        bus.call_valid = 1'b0;
    endtask

    // Waits (bounded) for an issue, then checks it and acks it for one cycle.
    task automatic expect_issue(input string tag, input int car, input logic [7:0] floor);
        int c;
        c = 0;
        while (bus.car_valid == 4'b0 && c < 20) begin
            tick();
            c++;
        end
        n_checks++;
        if (bus.car_valid !== (4'b0001 << car)) begin
            n_fails++;
            $display("FAIL %s_valid: got %b want %b", tag, bus.car_valid, 4'b0001 << car);
        end
        n_checks++;
        if (bus.route_data !== floor) begin
            n_fails++;
            $display("FAIL %s_data: got %h want %h", tag, bus.route_data, floor);
        end
        bus.car_ack = 4'b0001 << car;
        tick();
        bus.car_ack = 4'b0;
    endtask

    task automatic test_reset();
        bus.call_valid = 1'b0;
        bus.call_floor = '0;
        bus.car_busy   = '0;
        bus.car_ack    = '0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.car_valid, bus.route_sel, bus.route_data} !== 14'b0) begin
            n_fails++;
            $display("FAIL reset_route: got %b/%b/%h want 0", bus.car_valid, bus.route_sel, bus.route_data);
        end
        n_checks++;
        if ({bus.call_ready, bus.dup_drop, bus.timeout_pulse, bus.pending} !== 6'b100000) begin
            n_fails++;
            $display("FAIL reset_status: got rdy=%b dup=%b to=%b pend=%0d want rdy=1 rest 0",
                     bus.call_ready, bus.dup_drop, bus.timeout_pulse, bus.pending);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_call();
        apply_reset();
        push(8'h05);
        n_checks++;
        if (bus.car_valid !== 4'b0000 || bus.pending !== 3'd1) begin
            n_fails++;
            $display("FAIL single_push: got valid=%b pend=%0d want 0000/1", bus.car_valid, bus.pending);
        end
        tick();
        n_checks++;
        if (bus.car_valid !== 4'b0001 || bus.route_sel !== 2'd0 || bus.route_data !== 8'h05) begin
            n_fails++;
            $display("FAIL single_grant: got %b/%0d/%h want 0001/0/05", bus.car_valid, bus.route_sel, bus.route_data);
        end
        bus.car_ack = 4'b0001;
        tick();
        bus.car_ack = 4'b0;
        n_checks++;
        if (bus.car_valid !== 4'b0000 || bus.pending !== 3'd0) begin
            n_fails++;
            $display("FAIL single_ack: got valid=%b pend=%0d want 0000/0", bus.car_valid, bus.pending);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] floors [5];
        floors = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        apply_reset();
        for (int i = 0; i < 4; i++) push(floors[i]);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) push(floors[4]);
            expect_issue($sformatf("rr%0d", i), i % 4, floors[i]);
        end
        n_checks++;
        if (bus.pending !== 3'd0) begin
            n_fails++;
            $display("FAIL rr_drain: got pend=%0d want 0", bus.pending);
        end
    endtask

    task automatic test_busy_mask();
        apply_reset();
        bus.car_busy = 4'b1011;
        push(8'h09);
        tick();
        n_checks++;
        if (bus.car_valid !== 4'b0100 || bus.route_sel !== 2'd2) begin
            n_fails++;
            $display("FAIL busy_grant: got %b/%0d want 0100/2", bus.car_valid, bus.route_sel);
        end
        bus.car_ack = 4'b0100;
        tick();
        bus.car_ack = 4'b0;
        bus.car_busy = 4'b1111;
        push(8'h0A);
        tick();
        tick();
        n_checks++;
        if (bus.car_valid !== 4'b0000 || bus.pending !== 3'd1) begin
            n_fails++;
            $display("FAIL busy_hold: got valid=%b pend=%0d want 0000/1", bus.car_valid, bus.pending);
        end
    endtask

    task automatic test_full();
        apply_reset();
        bus.car_busy = 4'hF;
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
        n_checks++;
        if (bus.call_ready !== 1'b0 || bus.pending !== 3'd4) begin
            n_fails++;
            $display("FAIL full_flag: got rdy=%b pend=%0d want 0/4", bus.call_ready, bus.pending);
        end
        push(8'h15);
        n_checks++;
        if (bus.pending !== 3'd4) begin
            n_fails++;
            $display("FAIL full_reject: got pend=%0d want 4", bus.pending);
        end
        bus.car_busy = 4'b1110;
        tick();
        n_checks++;
        if (bus.car_valid !== 4'b0001 || bus.route_data !== 8'h11 || bus.call_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL full_grant: got %b/%h rdy=%b want 0001/11 rdy=0", bus.car_valid, bus.route_data, bus.call_ready);
        end
        bus.car_ack = 4'b0001;
        tick();
        bus.car_ack = 4'b0;
        n_checks++;
        if (bus.call_ready !== 1'b1 || bus.pending !== 3'd3) begin
            n_fails++;
            $display("FAIL full_pop: got rdy=%b pend=%0d want 1/3", bus.call_ready, bus.pending);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push(8'h21);
        tick();
        // push and ack on the same edge: occupancy stays at 1
        bus.call_valid = 1'b1;
        bus.call_floor = 8'h22;
        bus.car_ack    = 4'b0001;
        tick();
        bus.call_valid = 1'b0;
        bus.car_ack    = 4'b0;
        n_checks++;
        if (bus.pending !== 3'd1 || bus.car_valid !== 4'b0000) begin
            n_fails++;
            $display("FAIL b2b_swap: got pend=%0d valid=%b want 1/0000", bus.pending, bus.car_valid);
        end
        tick();
        n_checks++;
        if (bus.car_valid !== 4'b0010 || bus.route_data !== 8'h22) begin
            n_fails++;
            $display("FAIL b2b_regrant: got %b/%h want 0010/22", bus.car_valid, bus.route_data);
        end
    endtask

    task automatic test_dup_and_reset();
        apply_reset();
        // duplicate of a queued (not yet issued) entry
        bus.car_busy = 4'hF;
        push(8'h30);
        push(8'h30);
        n_checks++;
        if (bus.dup_drop !== 1'b1 || bus.pending !== 3'd1) begin
            n_fails++;
            $display("FAIL dup_queued: got dup=%b pend=%0d want 1/1", bus.dup_drop, bus.pending);
        end
        apply_reset();
        push(8'h07);
        tick();
        push(8'h07);
        n_checks++;
        if (bus.dup_drop !== 1'b1 || bus.pending !== 3'd1 || bus.call_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL dup_inflight: got dup=%b pend=%0d rdy=%b want 1/1/1", bus.dup_drop, bus.pending, bus.call_ready);
        end
        tick();
        n_checks++;
        if (bus.dup_drop !== 1'b0) begin
            n_fails++;
            $display("FAIL dup_pulse: got dup=%b want 0", bus.dup_drop);
        end
`ifndef DISPATCH_TIMEOUT_EN
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (bus.car_valid !== 4'b0001 || bus.timeout_pulse !== 1'b0) begin
            n_fails++;
            $display("FAIL hold_forever: got valid=%b to=%b want 0001/0", bus.car_valid, bus.timeout_pulse);
        end
`endif
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.car_valid !== 4'b0000 || bus.pending !== 3'd0) begin
            n_fails++;
            $display("FAIL mid_reset: got valid=%b pend=%0d want 0000/0", bus.car_valid, bus.pending);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        push(8'h31);
        tick();
        // grant edge just passed; 15 un-acked ISSUE cycles follow
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (bus.timeout_pulse !== 1'b0 || bus.car_valid !== 4'b0001) begin
            n_fails++;
            $display("FAIL to_early: got to=%b valid=%b want 0/0001", bus.timeout_pulse, bus.car_valid);
        end
        tick();
        n_checks++;
        if (bus.timeout_pulse !== 1'b1 || bus.car_valid !== 4'b0000 || bus.pending !== 3'd1) begin
            n_fails++;
            $display("FAIL to_fire: got to=%b valid=%b pend=%0d want 1/0000/1", bus.timeout_pulse, bus.car_valid, bus.pending);
        end
        tick();
        n_checks++;
        if (bus.timeout_pulse !== 1'b0 || bus.car_valid !== 4'b0010 || bus.route_data !== 8'h31) begin
            n_fails++;
            $display("FAIL to_retry: got to=%b %b/%h want 0/0010/31", bus.timeout_pulse, bus.car_valid, bus.route_data);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b1;
        test_reset();
        test_single_call();
        test_round_robin();
        test_busy_mask();
        test_full();
        test_back_to_back();
        test_dup_and_reset();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
